sha2_share_checker: RTL

- Downstream consumer of the double-SHA256 pipeline's result interface (digest_out/valid_out).
- Tracks the nonce issued with each write_en through a latency-matched delay line.
- Byte-reverses each result digest and compares it, as an unsigned 256-bit number, against a loaded target.
- Queues winning nonces in a small FIFO with a valid/ready handshake towards the host or UART side.

---
 rtl/sha2_share_checker_if.sv | 38 +++
 rtl/sha2_share_checker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sha2_share_checker_if.sv
// Result/winner bus between the double-SHA256 pipeline side, the target
// loader and the host-side winner consumer of sha2_share_checker.
// Optional macro: SHA2_CHECK_DIGEST_EN adds found_digest (head entry's hash_le).
interface sha2_share_checker_if;
    logic         write_en;
    logic [31:0]  nonce_in;
    logic         valid_in;
    logic [255:0] digest_in;
    logic         target_we;
    logic [255:0] target_in;
    logic         found_valid;
    logic         found_ready;
    logic [31:0]  found_nonce;
    logic [47:0]  hash_count;
    logic [15:0]  drop_count;
    logic         sync_err;
`ifdef SHA2_CHECK_DIGEST_EN
    logic [255:0] found_digest;
`endif

    // Host / pipeline side: drives blocks, results, target and ready.
    modport master (
        output write_en, nonce_in, valid_in, digest_in, target_we, target_in, found_ready,
`ifdef SHA2_CHECK_DIGEST_EN
        input  found_digest,
`endif
        input  found_valid, found_nonce, hash_count, drop_count, sync_err
    );

    // Checker side.
    modport slave (
        input  write_en, nonce_in, valid_in, digest_in, target_we, target_in, found_ready,
`ifdef SHA2_CHECK_DIGEST_EN
        output found_digest,
`endif
        output found_valid, found_nonce, hash_count, drop_count, sync_err
    );
endinterface

// File: rtl/sha2_share_checker.sv
// Share checker behind the double-SHA256 pipeline: tracks issued nonces
// through a latency-matched delay line, byte-reverses each result digest,
// compares it against the loaded target and queues winners in a small FIFO.
// Optional macro: SHA2_CHECK_DIGEST_EN stores hash_le per entry and drives
// found_digest with the same timing as found_nonce.
module sha2_share_checker #(
    parameter int LATENCY    = 65,
    parameter int FIFO_DEPTH = 4
) (
    input logic CLK,
    input logic RST,
    sha2_share_checker_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Digest bytes come out of the pipeline big-end first; the share test
    // treats the hash as a little-endian number.
    function automatic logic [255:0] byte_rev(input logic [255:0] d);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[255-8*i -: 8];
        end
        return r;
    endfunction

    logic [LATENCY-1:0] dly_vld_q;
    logic [31:0]        dly_nonce_q [LATENCY];
    logic [255:0]       target_q, target_d;
    logic [31:0]        fifo_nonce_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_after_pop;
    logic               found_valid_q, found_valid_d;
    logic [31:0]        found_nonce_q, found_nonce_d;
    logic [47:0]        hash_count_q, hash_count_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic               sync_err_q, sync_err_d;
    logic               tail_vld, hit, push_req, pop, full, push, drop;
    logic [31:0]        tail_nonce;
    logic [255:0]       hash_le;
`ifdef SHA2_CHECK_DIGEST_EN
    logic [255:0]       fifo_dig_q [FIFO_DEPTH];
    logic [255:0]       found_digest_q, found_digest_d;
`endif

    assign tail_vld   = dly_vld_q[LATENCY-1];
    assign tail_nonce = dly_nonce_q[LATENCY-1];
    assign hash_le    = byte_rev(bus.digest_in);
    assign hit        = (hash_le <= target_q);

    // Compare, FIFO bookkeeping and counters; head registers show the
    // post-edge head so found_* are valid one cycle after a push.
    always_comb begin
        push_req      = bus.valid_in && tail_vld && hit;
        pop           = found_valid_q && bus.found_ready;
        full          = (cnt_q == DEPTH_C);
        push          = push_req && (!full || pop);
        drop          = push_req && full && !pop;
        cnt_after_pop = cnt_q - {{(CNT_W-1){1'b0}}, pop};
        cnt_d         = cnt_after_pop + {{(CNT_W-1){1'b0}}, push};
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        found_valid_d = (cnt_d != '0);
        found_nonce_d = found_nonce_q;
`ifdef SHA2_CHECK_DIGEST_EN
        found_digest_d = found_digest_q;
`endif
        if (cnt_after_pop == '0) begin
            // Queue drained (or was empty): only a landing push can be the head.
            if (push) begin
                found_nonce_d = tail_nonce;
`ifdef SHA2_CHECK_DIGEST_EN
                found_digest_d = hash_le;
`endif
            end
        end else begin
            found_nonce_d = fifo_nonce_q[rd_ptr_d];
`ifdef SHA2_CHECK_DIGEST_EN
            found_digest_d = fifo_dig_q[rd_ptr_d];
`endif
        end
        hash_count_d = hash_count_q + {47'd0, bus.valid_in};
        drop_count_d = (drop && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1 : drop_count_q;
        sync_err_d   = sync_err_q || (bus.valid_in && !tail_vld);
        target_d     = bus.target_we ? bus.target_in : target_q;
    end

    // Latency-matched {valid, nonce} delay line; shifts every edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dly_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) dly_nonce_q[i] <= '0;
        end else begin
            dly_vld_q      <= {dly_vld_q[LATENCY-2:0], bus.write_en};
            dly_nonce_q[0] <= bus.nonce_in;
            for (int i = 1; i < LATENCY; i++) dly_nonce_q[i] <= dly_nonce_q[i-1];
        end
    end

    // Winner storage; pointers are reset elsewhere so contents need no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_nonce_q[wr_ptr_q] <= tail_nonce;
`ifdef SHA2_CHECK_DIGEST_EN
            fifo_dig_q[wr_ptr_q]   <= hash_le;
`endif
        end
    end

    // Control, counters, target and head registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            target_q      <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            found_valid_q <= 1'b0;
            found_nonce_q <= '0;
            hash_count_q  <= '0;
            drop_count_q  <= '0;
            sync_err_q    <= 1'b0;
`ifdef SHA2_CHECK_DIGEST_EN
            found_digest_q <= '0;
`endif
        end else begin
            target_q      <= target_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            found_valid_q <= found_valid_d;
            found_nonce_q <= found_nonce_d;
            hash_count_q  <= hash_count_d;
            drop_count_q  <= drop_count_d;
            sync_err_q    <= sync_err_d;
`ifdef SHA2_CHECK_DIGEST_EN
            found_digest_q <= found_digest_d;
`endif
        end
    end

    assign bus.found_valid = found_valid_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.hash_count  = hash_count_q;
    assign bus.drop_count  = drop_count_q;
    assign bus.sync_err    = sync_err_q;
`ifdef SHA2_CHECK_DIGEST_EN
    assign bus.found_digest = found_digest_q;
`endif
endmodule
